// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over a valid/ready handshake,
// with programmable wait states, byte/half/word lane steering and misalignment errors.
module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [1:0]            mem_size,
    input  logic                  mem_unsigned,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_err
);

    localparam int         WORD_AW   = ADDR_WIDTH - 2;
    localparam int         DEPTH     = 2 ** WORD_AW;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    cur_we;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [1:0]              cur_size;
    logic                    cur_uns;
    logic [DATA_WIDTH-1:0]   cur_wdata;
    logic                    cur_err;
    logic [WORD_AW-1:0]      word_idx;
    logic [DATA_WIDTH-1:0]   old_word;
    logic [DATA_WIDTH-1:0]   new_word;
    logic [DATA_WIDTH-1:0]   wr_lanes;
    logic [DATA_WIDTH-1:0]   shifted;
    logic [DATA_WIDTH-1:0]   load_val;
    logic [3:0]              byte_en;
    logic                    enter_resp;
    logic                    mem_wr_en;

    // In IDLE the response may be produced on the sampling edge itself
    // (zero wait states), so the live request fields are used there.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_we    = mem_we;
            cur_addr  = mem_addr;
            cur_size  = mem_size;
            cur_uns   = mem_unsigned;
            cur_wdata = mem_wdata;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_size  = size_q;
            cur_uns   = uns_q;
            cur_wdata = wdata_q;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        cur_err  = (cur_size == 2'b11)
                 | ((cur_size == SZ_HALF) & cur_addr[0])
                 | ((cur_size == SZ_WORD) & (cur_addr[1:0] != 2'b00));
        word_idx = cur_addr[ADDR_WIDTH-1:2];
        old_word = mem_q[word_idx];
        byte_en  = 4'b1111;
        wr_lanes = cur_wdata;
        case (cur_size)
            SZ_BYTE: begin
                byte_en  = 4'b0001 << cur_addr[1:0];
                wr_lanes = {4{cur_wdata[7:0]}};
            end
            SZ_HALF: begin
                byte_en  = cur_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{cur_wdata[15:0]}};
            end
            default: ;
        endcase

        new_word = old_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) new_word[8*b +: 8] = wr_lanes[8*b +: 8];
        end

        shifted  = old_word >> {cur_addr[1:0], 3'b000};
        load_val = shifted;
        case (cur_size)
            SZ_BYTE: load_val = {{24{~cur_uns & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_val = {{16{~cur_uns & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    we_d    = mem_we;
                    addr_d  = mem_addr;
                    size_d  = mem_size;
                    uns_d   = mem_unsigned;
                    wdata_d = mem_wdata;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_STATES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        mem_wr_en = enter_resp & cur_we & ~cur_err;
        rdata_d   = (enter_resp & ~cur_we & ~cur_err) ? load_val : '0;
        err_d     = enter_resp & cur_err;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array is deliberately not reset (contents survive reset and it maps onto RAM); writes are only gated off while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && mem_wr_en) mem_q[word_idx] <= new_word;
    end

    assign mem_ready = (state_q == S_RESP);
    assign mem_rdata = rdata_q;
    assign mem_err   = err_q;

endmodule
